// File: rtl/pcf8575_target_emu_if.sv
// I2C bus-side signals of the PCF8575 target emulator.
// The master drives SCL/SDA levels as seen on the wire; the target returns its pull-down enable.
interface pcf8575_target_emu_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe
    );
endinterface

// File: rtl/pcf8575_target_emu.sv
// PCF8575 16-bit I/O expander target.
// Decodes {4'b0100, ADDR_PINS}, latches written bytes to port_out (low byte first),
// returns synchronized input pins on reads and flags any input change on int_o.
module pcf8575_target_emu #(
    parameter logic [2:0]  ADDR_PINS   = 3'b000,
    parameter logic [15:0] PORT_RESET  = 16'hFFFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    pcf8575_target_emu_if.slave        bus,
    input  logic [15:0]                p_in,
    output logic [15:0]                port_out,
    output logic                       int_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWait
    } state_e;

    localparam logic [6:0] DevAddr = {4'b0100, ADDR_PINS};

    logic [SYNC_STAGES-1:0]       scl_sync, sda_sync;
    logic [SYNC_STAGES-1:0][15:0] p_sync;
    logic                         scl_prev, sda_prev;
    logic                         scl_s, sda_s;
    logic [15:0]                  p_s;
    logic                         scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] port_q, port_d;
    logic        byte_hi_q, byte_hi_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        int_q, int_d;

    logic [7:0]  rd_byte;
    logic [2:0]  nxt_idx;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign p_s   = p_sync[SYNC_STAGES-1];

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    // Byte currently being shifted out and the index of its next bit (MSB first)
    assign rd_byte = byte_hi_q ? shift_q[15:8] : shift_q[7:0];
    assign nxt_idx = 3'd6 - bit_cnt_q[2:0];

    assign bus.sda_oe = sda_oe_q;
    assign port_out   = port_q;
    assign int_o      = int_q;

    // Input synchronizers and one-cycle history for edge detection; idle bus reads high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            p_sync   <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            p_sync   <= {p_sync[SYNC_STAGES-2:0], p_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    // Protocol state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            rx_q      <= 8'h00;
            shift_q   <= 16'h0000;
            snap_q    <= 16'hFFFF;
            port_q    <= PORT_RESET;
            byte_hi_q <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            shift_q   <= shift_d;
            snap_q    <= snap_d;
            port_q    <= port_d;
            byte_hi_q <= byte_hi_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            int_q     <= int_d;
        end
    end

    // Next-state logic; sda_oe only moves on SCL falls (or on START/STOP, releasing)
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        shift_d   = shift_q;
        snap_d    = snap_q;
        port_d    = port_q;
        byte_hi_d = byte_hi_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        int_d     = (p_s != snap_q);

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                StAddr, StWrByte: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        rx_d      = {rx_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == StWrByte) begin
                            state_d  = StWrAck;
                            sda_oe_d = 1'b1;
                        end else if (rx_q[7:1] == DevAddr) begin
                            state_d  = StAddrAck;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        byte_hi_d = 1'b0;
                        if (rx_q[0]) begin
                            state_d  = StRdByte;
                            shift_d  = p_s;
                            snap_d   = p_s;
                            sda_oe_d = ~p_s[7];
                        end else begin
                            state_d  = StWrByte;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_rise) begin
                        if (byte_hi_q) begin
                            port_d[15:8] = rx_q;
                        end else begin
                            port_d[7:0] = rx_q;
                        end
                        byte_hi_d = ~byte_hi_q;
                        snap_d    = p_s;
                    end else if (scl_fall) begin
                        state_d   = StWrByte;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                    end
                end
                StRdByte: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            state_d   = StRdAck;
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            sda_oe_d  = ~rd_byte[nxt_idx];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (mack_q) begin
                            state_d = StRdByte;
                            if (byte_hi_q) begin
                                // Both bytes sent: take a fresh snapshot of the pins
                                shift_d   = p_s;
                                snap_d    = p_s;
                                byte_hi_d = 1'b0;
                                sda_oe_d  = ~p_s[7];
                            end else begin
                                byte_hi_d = 1'b1;
                                sda_oe_d  = ~shift_q[15];
                            end
                        end else begin
                            state_d  = StWait;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcf8575_target_emu.sv
// Directed bench for pcf8575_target_emu: bit-banged I2C master with hand-computed expectations.
module tb_pcf8575_target_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m;
    logic [15:0] p_in;
    logic [15:0] port_out;
    logic        int_o;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic watch   = 1'b0;
    logic seen_oe = 1'b0;

    pcf8575_target_emu_if bus ();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    pcf8575_target_emu #(
        .ADDR_PINS   (3'b000),
        .PORT_RESET  (16'hFFFF),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .p_in     (p_in),
        .port_out (port_out),
        .int_o    (int_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch && bus.sda_oe) seen_oe = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Quarter SCL period
    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = bus.sda_i; q();
        scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         n;
        logic [7:0] partial;

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        p_in  = 16'hFFFF;
        repeat (5) @(negedge clk);
        check("reset_sda_oe", {15'd0, bus.sda_oe}, 16'h0000);
        check("reset_port", port_out, 16'hFFFF);
        check("reset_int", {15'd0, int_o}, 16'h0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: write 0x5F, 0xF5 to address 0x20
        i2c_start();
        write_byte(8'h40, ack); check("t1_addr_ack", {15'd0, ack}, 16'h0001);
        write_byte(8'h5F, ack); check("t1_d0_ack", {15'd0, ack}, 16'h0001);
        check("t1_port_after_d0", port_out, 16'hFF5F);
        write_byte(8'hF5, ack); check("t1_d1_ack", {15'd0, ack}, 16'h0001);
        check("t1_port_after_d1", port_out, 16'hF55F);
        i2c_stop();

        // 2: wrong address 0x42 is never acknowledged
        seen_oe = 1'b0;
        watch   = 1'b1;
        i2c_start();
        write_byte(8'h84, ack); check("t2_addr_nack", {15'd0, ack}, 16'h0000);
        write_byte(8'h00, ack); check("t2_data_nack", {15'd0, ack}, 16'h0000);
        i2c_stop();
        watch = 1'b0;
        check("t2_sda_never_low", {15'd0, seen_oe}, 16'h0000);
        check("t2_port_kept", port_out, 16'hF55F);

        // 3: read two bytes of p_in, low byte first
        p_in = 16'hA5C3;
        i2c_start();
        write_byte(8'h41, ack); check("t3_addr_ack", {15'd0, ack}, 16'h0001);
        read_byte(d, 1'b1); check("t3_byte_lo", {8'h00, d}, 16'h00C3);
        read_byte(d, 1'b0); check("t3_byte_hi", {8'h00, d}, 16'h00A5);
        check("t3_released", {15'd0, bus.sda_oe}, 16'h0000);
        i2c_stop();
        check("t3_int_quiet", {15'd0, int_o}, 16'h0000);

        // 4: interrupt on input change, cleared by a read address ACK
        p_in = 16'hFFFF;
        i2c_start();
        write_byte(8'h41, ack);
        read_byte(d, 1'b0);
        i2c_stop();
        check("t4_int_idle", {15'd0, int_o}, 16'h0000);
        p_in = 16'hFFFE;
        n = 0;
        while (!int_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t4_int_set", {15'd0, int_o}, 16'h0001);
        check("t4_int_latency", {15'd0, (n <= 4)}, 16'h0001);
        i2c_start();
        write_byte(8'h41, ack); check("t4_addr_ack", {15'd0, ack}, 16'h0001);
        check("t4_int_cleared", {15'd0, int_o}, 16'h0000);
        read_byte(d, 1'b0); check("t4_byte_lo", {8'h00, d}, 16'h00FE);
        i2c_stop();

        // 5: reset in the middle of a data byte, then a clean write
        i2c_start();
        write_byte(8'h40, ack);
        partial = 8'h12;
        for (int i = 7; i >= 4; i--) write_bit(partial[i]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_rst_sda_oe", {15'd0, bus.sda_oe}, 16'h0000);
        check("t5_rst_port", port_out, 16'hFFFF);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        i2c_stop();
        i2c_start();
        write_byte(8'h40, ack); check("t5_addr_ack", {15'd0, ack}, 16'h0001);
        write_byte(8'h34, ack); check("t5_d0_ack", {15'd0, ack}, 16'h0001);
        write_byte(8'h12, ack); check("t5_d1_ack", {15'd0, ack}, 16'h0001);
        i2c_stop();
        check("t5_port", port_out, 16'h1234);

        // 6: one data byte, repeated START into a read
        i2c_start();
        write_byte(8'h40, ack);
        write_byte(8'hAA, ack); check("t6_d0_ack", {15'd0, ack}, 16'h0001);
        i2c_start();
        write_byte(8'h41, ack); check("t6_rs_addr_ack", {15'd0, ack}, 16'h0001);
        read_byte(d, 1'b0);
        i2c_stop();
        check("t6_port", port_out, 16'h12AA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
